// File: rtl/hwpe_dma_loader.sv
// Packs IN_W stream beats into DATA_W words and writes them over up to N_REG regions; write issues the cycle after a word's last beat.
// s_ready is high only while running (one beat per cycle, no bubbles); HWPE_DMA_LDR_BIGEND_EN puts the first beat in the MSBs.
`ifndef HWPE_ADDR_WIDTH
`define HWPE_ADDR_WIDTH 32
`endif

module hwpe_dma_loader #(
    parameter int DATA_W = 64,
    parameter int IN_W   = 8,
    parameter int ADDR_W = `HWPE_ADDR_WIDTH,
    parameter int N_REG  = 4,
    parameter int LEN_W  = 16,
    localparam int IDX_W = (N_REG > 1) ? $clog2(N_REG) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_wen,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [IN_W-1:0]   s_data,
    output logic              dma_wen,
    output logic [ADDR_W-1:0] dma_wa,
    output logic [DATA_W-1:0] dma_wd,
    output logic              busy,
    output logic              done,
    output logic [31:0]       words_wr
);
    localparam int BPW    = DATA_W / IN_W;
    localparam int BEAT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int BYTES  = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q [N_REG];
    logic [LEN_W-1:0]  len_q  [N_REG];
    logic [IDX_W-1:0]  reg_q, reg_d;
    logic [LEN_W-1:0]  word_q, word_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [DATA_W-1:0] pack_q, pack_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [31:0]       cnt_q, cnt_d;

    logic              first_vld, next_vld;
    logic [IDX_W-1:0]  first_idx, next_idx;

    // Descending scan so the last hit is the lowest qualifying region.
    always_comb begin
        first_vld = 1'b0;
        first_idx = '0;
        next_vld  = 1'b0;
        next_idx  = '0;
        for (int i = N_REG - 1; i >= 0; i--) begin
            if (len_q[i] != '0) begin
                first_vld = 1'b1;
                first_idx = IDX_W'(i);
                if (IDX_W'(i) > reg_q) begin
                    next_vld = 1'b1;
                    next_idx = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        word_d  = word_q;
        beat_d  = beat_q;
        pack_d  = pack_q;
        wen_d   = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    reg_d   = first_idx;
                    word_d  = '0;
                    beat_d  = '0;
                    cnt_d   = '0;
                    state_d = first_vld ? RUN : DONE;
                end
            end
            RUN: begin
                if (s_valid) begin
                    for (int j = 0; j < BPW; j++) begin
                        if (beat_q == BEAT_W'(j)) begin
`ifdef HWPE_DMA_LDR_BIGEND_EN
                            pack_d[DATA_W-IN_W*(j+1) +: IN_W] = s_data;
`else
                            pack_d[IN_W*j +: IN_W] = s_data;
`endif
                        end
                    end
                    if (beat_q == BEAT_W'(BPW - 1)) begin
                        beat_d = '0;
                        wen_d  = 1'b1;
                        wa_d   = base_q[reg_q] + ADDR_W'(word_q) * ADDR_W'(BYTES);
                        wd_d   = pack_d;
                        cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
                        if (word_q == len_q[reg_q] - 1'b1) begin
                            word_d = '0;
                            if (next_vld) begin
                                reg_d = next_idx;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            word_d = word_q + 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over start and beats: drop the partial word and any write being formed.
        if (abort) begin
            state_d = IDLE;
            beat_d  = '0;
            pack_d  = pack_q;
            wen_d   = 1'b0;
            wa_d    = wa_q;
            wd_d    = wd_q;
            cnt_d   = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REG; i++) begin
                base_q[i] <= '0;
                len_q[i]  <= '0;
            end
        end else if (cfg_wen && state_q == IDLE) begin
            base_q[cfg_idx] <= cfg_base;
            len_q[cfg_idx]  <= cfg_len;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            reg_q   <= '0;
            word_q  <= '0;
            beat_q  <= '0;
            pack_q  <= '0;
            wen_q   <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            word_q  <= word_d;
            beat_q  <= beat_d;
            pack_q  <= pack_d;
            wen_q   <= wen_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s_ready  = (state_q == RUN);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign dma_wen  = wen_q;
    assign dma_wa   = wa_q;
    assign dma_wd   = wd_q;
    assign words_wr = cnt_q;
endmodule

// File: tb/tb_hwpe_dma_loader.sv
// Bench for hwpe_dma_loader: table-driven region jobs, randomized jobs against a stream model, abort/reset/IN_W=32 sequences.
`timescale 1ns/1ps
module tb_hwpe_dma_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        cfg_wen = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [31:0] cfg_base = '0;
    logic [15:0] cfg_len = '0;
    logic        start = 1'b0, abort = 1'b0, s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = '0;
    logic        dma_wen, busy, done;
    logic [31:0] dma_wa, words_wr;
    logic [63:0] dma_wd;

    logic        b_cfg_wen = 1'b0, b_start = 1'b0, b_abort = 1'b0, b_s_valid = 1'b0;
    logic [1:0]  b_cfg_idx = '0;
    logic [31:0] b_cfg_base = '0, b_s_data = '0;
    logic [15:0] b_cfg_len = '0;
    logic        b_s_ready, b_dma_wen, b_busy, b_done;
    logic [31:0] b_dma_wa, b_words_wr;
    logic [63:0] b_dma_wd;

    hwpe_dma_loader #(.DATA_W(64), .IN_W(8), .ADDR_W(32), .N_REG(4), .LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_wen(cfg_wen), .cfg_idx(cfg_idx), .cfg_base(cfg_base),
        .cfg_len(cfg_len), .start(start), .abort(abort), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .dma_wen(dma_wen), .dma_wa(dma_wa), .dma_wd(dma_wd), .busy(busy),
        .done(done), .words_wr(words_wr));

    hwpe_dma_loader #(.DATA_W(64), .IN_W(32), .ADDR_W(32), .N_REG(4), .LEN_W(16)) dut32 (
        .clk(clk), .rst_n(rst_n), .cfg_wen(b_cfg_wen), .cfg_idx(b_cfg_idx), .cfg_base(b_cfg_base),
        .cfg_len(b_cfg_len), .start(b_start), .abort(b_abort), .s_valid(b_s_valid), .s_ready(b_s_ready),
        .s_data(b_s_data), .dma_wen(b_dma_wen), .dma_wa(b_dma_wa), .dma_wd(b_dma_wd), .busy(b_busy),
        .done(b_done), .words_wr(b_words_wr));

    typedef struct {
        logic [31:0] wa;
        logic [63:0] wd;
        logic        dn;
        int          cy;
    } wr_t;

    int   cyc = 0;
    wr_t  wr_q[$];
    wr_t  wr32_q[$];
    wr_t  mon_w;
    int   acc_q[$];
    int   done_cnt = 0;
    int   n_chk = 0, n_pass = 0;
    int   job_t0 = 0;
    logic [7:0] stim[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (s_valid && s_ready) acc_q.push_back(cyc);
        if (dma_wen) begin
            mon_w.wa = dma_wa; mon_w.wd = dma_wd; mon_w.dn = done; mon_w.cy = cyc;
            wr_q.push_back(mon_w);
        end
        if (b_dma_wen) begin
            mon_w.wa = b_dma_wa; mon_w.wd = b_dma_wd; mon_w.dn = b_done; mon_w.cy = cyc;
            wr32_q.push_back(mon_w);
        end
        if (done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d checks", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Spec-level packing: beat j of a word is byte j of the stream chunk.
    function automatic logic [63:0] pack_word(input int off);
        logic [63:0] w = '0;
        for (int j = 0; j < 8; j++) begin
`ifdef HWPE_DMA_LDR_BIGEND_EN
            w[56-8*j +: 8] = stim[off+j];
`else
            w[8*j +: 8] = stim[off+j];
`endif
        end
        return w;
    endfunction

    task automatic program_desc(input logic [3:0][31:0] b, input logic [3:0][15:0] l);
        for (int i = 0; i < 4; i++) begin
            cfg_wen = 1'b1; cfg_idx = 2'(i); cfg_base = b[i]; cfg_len = l[i];
            tick();
        end
        cfg_wen = 1'b0;
    endtask

    task automatic run_job(input string nm, input logic [3:0][31:0] b, input logic [3:0][15:0] l, input bit gaps);
        wr_t exp_q[$];
        wr_t e;
        int  nw = 0, beats, idx = 0, guard = 0, d0;
        bit  acc, ok;
        program_desc(b, l);
        stim.delete();
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < int'(l[r]); k++) nw++;
        beats = nw * 8;
        for (int i = 0; i < beats; i++) stim.push_back(gaps ? 8'($urandom) : 8'(i));
        nw = 0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < int'(l[r]); k++) begin
                e.wa = b[r] + 32'(k) * 32'd8; e.wd = pack_word(nw * 8); e.dn = 1'b0; e.cy = 0;
                exp_q.push_back(e);
                nw++;
            end
        end
        if (nw > 0) exp_q[nw-1].dn = 1'b1;
        wr_q.delete(); acc_q.delete(); d0 = done_cnt;
        start = 1'b1; job_t0 = cyc; tick(); start = 1'b0;
        while (idx < beats && guard < 2000) begin
            s_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
            s_data  = stim[idx];
            acc = s_valid && s_ready;
            tick();
            if (acc) idx++;
            guard++;
        end
        s_valid = 1'b0;
        chk({nm, " beats_taken"}, idx, beats);
        chk({nm, " ready_after_last"}, s_ready, 1'b0);
        chk({nm, " done_cycle"}, done, 1'b1);
        tick(); tick();
        chk({nm, " idle_after"}, busy, 1'b0);
        chk({nm, " done_pulses"}, done_cnt - d0, 1);
        chk({nm, " words_wr"}, words_wr, nw);
        chk({nm, " n_writes"}, wr_q.size(), nw);
        for (int n = 0; n < nw && n < wr_q.size(); n++) begin
            chk($sformatf("%s wa%0d", nm, n), wr_q[n].wa, exp_q[n].wa);
            chk($sformatf("%s wd%0d", nm, n), wr_q[n].wd, exp_q[n].wd);
            chk($sformatf("%s done_on_wr%0d", nm, n), wr_q[n].dn, exp_q[n].dn);
            if (acc_q.size() >= (n + 1) * 8)
                chk($sformatf("%s wr_cycle%0d", nm, n), wr_q[n].cy, acc_q[(n+1)*8-1] + 1);
        end
        if (!gaps && beats > 0) begin
            ok = (acc_q.size() == beats);
            for (int i = 0; i < acc_q.size(); i++) if (acc_q[i] != job_t0 + 1 + i) ok = 1'b0;
            chk({nm, " no_bubbles"}, ok, 1'b1);
        end
    endtask

    typedef struct {
        string             nm;
        logic [3:0][31:0]  b;
        logic [3:0][15:0]  l;
        int                words;
        logic [31:0]       wa0;
        logic [31:0]       wan;
    } vec_t;

    vec_t tbl[5];
    logic [63:0] wd0_exp, wd_restart_exp, wd32_exp;
    logic [3:0][31:0] rb;
    logic [3:0][15:0] rl;
    int d0;

    initial begin
`ifdef HWPE_DMA_LDR_BIGEND_EN
        wd0_exp = 64'h0001020304050607; wd_restart_exp = 64'h1011121314151617; wd32_exp = 64'h0302010007060504;
`else
        wd0_exp = 64'h0706050403020100; wd_restart_exp = 64'h1716151413121110; wd32_exp = 64'h0706050403020100;
`endif
        for (int i = 0; i < 5; i++) begin tbl[i].b = '0; tbl[i].l = '0; end
        tbl[0].nm = "two_words";  tbl[0].l[0] = 16'd2; tbl[0].words = 2; tbl[0].wa0 = 32'h0; tbl[0].wan = 32'h8;
        tbl[1].nm = "skip_r1";    tbl[1].l[0] = 16'd1; tbl[1].b[2] = 32'h4000; tbl[1].l[2] = 16'd1;
        tbl[1].words = 2; tbl[1].wa0 = 32'h0; tbl[1].wan = 32'h4000;
        tbl[2].nm = "all_zero";   tbl[2].words = 0; tbl[2].wa0 = 32'h0; tbl[2].wan = 32'h0;
        tbl[3].nm = "addr_wrap";  tbl[3].b[3] = 32'hFFFF_FFF8; tbl[3].l[3] = 16'd2;
        tbl[3].words = 2; tbl[3].wa0 = 32'hFFFF_FFF8; tbl[3].wan = 32'h0;
        tbl[4].nm = "r1_three";   tbl[4].b[1] = 32'h100; tbl[4].l[1] = 16'd3;
        tbl[4].words = 3; tbl[4].wa0 = 32'h100; tbl[4].wan = 32'h110;

        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst s_ready", s_ready, 0); chk("rst dma_wen", dma_wen, 0); chk("rst dma_wa", dma_wa, 0);
        chk("rst dma_wd", dma_wd, 0); chk("rst busy", busy, 0); chk("rst done", done, 0);
        chk("rst words_wr", words_wr, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_job(tbl[i].nm, tbl[i].b, tbl[i].l, 1'b0);
            chk({tbl[i].nm, " tbl_words"}, words_wr, tbl[i].words);
            if (tbl[i].words > 0 && wr_q.size() > 0) begin
                chk({tbl[i].nm, " tbl_wa0"}, wr_q[0].wa, tbl[i].wa0);
                chk({tbl[i].nm, " tbl_wan"}, wr_q[wr_q.size()-1].wa, tbl[i].wan);
                chk({tbl[i].nm, " tbl_wd0"}, wr_q[0].wd, wd0_exp);
                chk({tbl[i].nm, " tbl_lat0"}, wr_q[0].cy - job_t0, 9);
            end
        end

        for (int it = 0; it < 6; it++) begin
            for (int r = 0; r < 4; r++) begin rb[r] = $urandom; rl[r] = 16'($urandom_range(3)); end
            run_job($sformatf("rand%0d", it), rb, rl, 1'b1);
        end

        // abort after 5 of 8 beats, with an ignored cfg write mid-run, then a clean restart
        rb = '0; rl = '0; rb[0] = 32'h80; rl[0] = 16'd1;
        program_desc(rb, rl);
        wr_q.delete(); d0 = done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = 8'hA0 + 8'(i);
            cfg_wen = (i == 2); cfg_idx = 2'd0; cfg_base = 32'h999; cfg_len = 16'd7;
            tick();
        end
        cfg_wen = 1'b0;
        abort = 1'b1; s_data = 8'hFF; tick(); abort = 1'b0; s_valid = 1'b0;
        chk("abort busy", busy, 0); chk("abort s_ready", s_ready, 0); chk("abort done", done, 0);
        repeat (3) tick();
        chk("abort no_write", wr_q.size(), 0); chk("abort no_done", done_cnt - d0, 0);
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        chk("abort_over_start busy", busy, 0);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_data = 8'h10 + 8'(i); start = (i == 3);
            tick();
        end
        s_valid = 1'b0; start = 1'b0;
        tick(); tick();
        chk("restart n_writes", wr_q.size(), 1);
        if (wr_q.size() > 0) begin
            chk("restart wa", wr_q[0].wa, 32'h80);
            chk("restart wd", wr_q[0].wd, wd_restart_exp);
        end
        chk("restart words_wr", words_wr, 1);

        // IN_W=32 instance
        b_cfg_wen = 1'b1; b_cfg_idx = 2'd0; b_cfg_base = 32'h100; b_cfg_len = 16'd1; tick(); b_cfg_wen = 1'b0;
        b_start = 1'b1; tick(); b_start = 1'b0;
        b_s_valid = 1'b1; b_s_data = 32'h03020100; tick();
        b_s_data = 32'h07060504; tick();
        b_s_valid = 1'b0; chk("w32 done", b_done, 1);
        tick(); tick();
        chk("w32 n_writes", wr32_q.size(), 1);
        if (wr32_q.size() > 0) begin
            chk("w32 wa", wr32_q[0].wa, 32'h100);
            chk("w32 wd", wr32_q[0].wd, wd32_exp);
        end
        chk("w32 words_wr", b_words_wr, 1);

        // reset mid-run
        rb = '0; rl = '0; rb[0] = 32'h200; rl[0] = 16'd2;
        program_desc(rb, rl);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin s_valid = 1'b1; s_data = 8'(i); tick(); end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst s_ready", s_ready, 0); chk("midrst dma_wen", dma_wen, 0); chk("midrst dma_wa", dma_wa, 0);
        chk("midrst dma_wd", dma_wd, 0); chk("midrst busy", busy, 0); chk("midrst done", done, 0);
        chk("midrst words_wr", words_wr, 0);
        wr_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (8) tick();
        s_valid = 1'b0;
        chk("postrst no_write", wr_q.size(), 0);
        chk("postrst ready", s_ready, 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("postrst desc_cleared_done", done, 1);
        tick(); tick();
        chk("postrst desc_cleared_nowrite", wr_q.size(), 0);
        chk("postrst words_wr", words_wr, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
